// File: rtl/freq_meter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | freq_meter_if: measurement bus between a controller and freq_meter |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq_out;
    logic             valid;
    logic             overflow;
    logic             busy;

    modport master (
        output en, sig_in,
        input  freq_out, valid, overflow, busy
    );

    modport slave (
        input  en, sig_in,
        output freq_out, valid, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | freq_meter: gated edge counter, publishes rising-edge count/window |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module freq_meter #(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int GATE_CYCLES = CLK_FREQ,
    parameter int CNT_W       = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    freq_meter_if.slave  bus
);
    localparam int             GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic             s1_q, s2_q, prev_q;
    logic [1:0]       prime_q;
    logic             rise_w;
    logic             cnt_max_w;
    logic [CNT_W-1:0] cnt_acc_w;
    logic             sat_acc_w;

    // prime_q keeps the reset-cleared synchronizer from faking a rise
    // when sig_in is already high at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            prime_q <= 2'd0;
        end else begin
            s1_q   <= bus.sig_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign rise_w    = s2_q & ~prev_q & (prime_q == 2'd3);
    assign cnt_max_w = (cnt_q == {CNT_W{1'b1}});
    assign cnt_acc_w = (rise_w && !cnt_max_w) ? cnt_q + CNT_W'(1) : cnt_q;
    assign sat_acc_w = sat_q | (rise_w & cnt_max_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                gate_d = '0;
                cnt_d  = '0;
                sat_d  = 1'b0;
                if (bus.en) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (gate_q == GATE_LAST) begin
                    // Terminal cycle closes the window even if en just fell.
                    freq_d  = cnt_acc_w;
                    ovf_d   = sat_acc_w;
                    valid_d = 1'b1;
                    gate_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    if (!bus.en) begin
                        state_d = S_IDLE;
                    end
                end else if (!bus.en) begin
                    state_d = S_IDLE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    gate_d = gate_q + GW'(1);
                    cnt_d  = cnt_acc_w;
                    sat_d  = sat_acc_w;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.freq_out = freq_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == S_MEASURE);
endmodule
`default_nettype wire

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter for the counter design: counts rising edges of an asynchronous input over a fixed gate window timed from the system clock, and publishes the count once per window.
- It is the measuring end of a divided-clock link: the divider output (or any slow external signal) feeds sig_in, and freq_out reads back its rate in Hz when the gate is 1 s.
- Used for bring-up checks of divider outputs and for the frequency display path.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- GATE_CYCLES, CLK_FREQ, gate window length in clk cycles (1 s default). Must be ≥ 4.
- CNT_W, 32, width of the edge counter and freq_out.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- en  in  1  measurement enable, synchronous.
- sig_in  in  1  signal under measurement, asynchronous to clk.
- freq_out  out  CNT_W  edge count of the last completed window.
- valid  out  1  one-cycle pulse when freq_out is updated.
- overflow  out  1  last completed window saturated.
- busy  out  1  high while a window is in progress.

Behaviour:
- Reset (rst=0, asynchronous): freq_out=0, valid=0, overflow=0, busy=0, state=IDLE, synchronizer and all counters cleared.
- Input conditioning: sig_in passes through a 2-flop synchronizer (s1→s2), then a prev flop. edge = s2 & ~prev. A sig_in rise is counted 3 clk edges after it is first sampled. A level that is high at or after reset is not an edge.
- FSM states IDLE, MEASURE:
  - IDLE: busy=0, gate_cnt=0, edge_cnt=0. en=1 → MEASURE on the next cycle.
  - MEASURE: busy=1. gate_cnt increments every cycle from 0 up to GATE_CYCLES-1. edge_cnt increments on each edge cycle.
  - Terminal cycle (gate_cnt==GATE_CYCLES-1): on the next clk, freq_out ← edge_cnt + edge (the edge in the terminal cycle counts toward the closing window), overflow ← saturation flag, valid=1 for exactly that cycle.
  - At the same clk, gate_cnt ← 0, edge_cnt ← 0 and the saturation flag clears. The next window starts back-to-back with no dead cycle.
  - Any MEASURE cycle with en=0 → IDLE on the next clk. The partial window is discarded, with no valid pulse and no freq_out update.
  - If en falls in the terminal cycle, the window still completes and valid still pulses, then the FSM enters IDLE.
- Saturation: edge_cnt stops at 2^CNT_W-1 and sets the saturation flag. It never wraps. A terminal-cycle edge also cannot push the latched value past the maximum.
- freq_out and overflow hold their value between updates, including through IDLE. Only reset clears them.
- Reset mid-window: all state clears immediately, with no valid pulse. After release, measurement restarts from gate_cnt=0 if en=1.
- Edges at or above CLK_FREQ/4 are not guaranteed to be counted. Below that, the count per window is exact: every edge detected in a MEASURE cycle lands in exactly one window.

Test Plan (GATE_CYCLES=100, CNT_W=8 unless stated):
- en=1, sig_in square wave with period 10 clk, phase chosen so no edge falls in the terminal cycle → valid pulses every 100 clk, freq_out=10, overflow=0, busy=1 continuously.
- en=1, sig_in held high from reset → freq_out=0 on every window. Then a single rise of sig_in → freq_out=1 in that window only, 0 in the next.
- CNT_W=4, sig_in period 4 clk (25 edges per window) → freq_out=15, overflow=1. Then sig_in period 20 (5 edges) → next window freq_out=5, overflow=0.
- en dropped at gate_cnt=50 → no valid pulse, busy=0 within 1 clk, freq_out retains its previous value. en re-raised → first valid pulse 101 clk later.
- rst pulsed low at gate_cnt=70 → all outputs 0 immediately. After release with en=1 and a period-10 stimulus, the first valid pulse arrives 101 clk after release with freq_out=10.
- Edge placed exactly in a terminal cycle → counted in the closing window (freq_out=N+1), and the following window does not include it.
